// File: rtl/inst_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_prefetch_queue
// Brief    : Sequential instruction fetch into a 1-cycle synchronous ROM,
//            DEPTH-entry buffer of {inst, PC}, valid/ready head to decode,
//            redirect with flush.
// Revision : 1.0 - initial release
// ============================================================================
module inst_prefetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_Redirect_1,
  input  logic [XLEN-1:0]            i_RedirectPC_32,
  output logic [XLEN-1:0]            o_RomAddr_32,
  output logic                       o_RomReq_1,
  input  logic [XLEN-1:0]            i_RomData_32,
  output logic                       o_Valid_1,
  output logic [XLEN-1:0]            o_Inst_32,
  output logic [XLEN-1:0]            o_PC_32,
  output logic [XLEN-1:0]            o_PCPlus4_32,
  input  logic                       i_Ready_1,
  output logic [$clog2(DEPTH+1)-1:0] o_Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  // One extra bit so count + inflight can reach DEPTH without overflow
  localparam int OW = CW + 1;
  localparam logic [OW-1:0] c_DEPTH = OW'(DEPTH);

  logic [XLEN-1:0] fpc_q, fpc_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [XLEN-1:0] mem_inst_q [DEPTH];
  logic [XLEN-1:0] mem_pc_q   [DEPTH];

  logic            w_pop;
  logic            w_push;
  logic            w_issue;
  logic [OW-1:0]   w_occ;

  // Handshake and fetch-credit: an issue is allowed only when the slot the
  // returning word will need is guaranteed free, counting this cycle's pop.
  always_comb begin
    w_pop   = (count_q != '0) && i_Ready_1;
    w_occ   = OW'(count_q) + OW'(inflight_q) - OW'(w_pop);
    w_issue = !rst && !i_Redirect_1 && (w_occ < c_DEPTH);
    w_push  = inflight_q && !i_Redirect_1;
  end

  // Next-state: redirect flushes everything and restarts fetch at the target
  always_comb begin
    fpc_d      = fpc_q;
    inflight_d = 1'b0;
    ipc_d      = ipc_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    count_d    = count_q;
    if (i_Redirect_1) begin
      fpc_d   = i_RedirectPC_32;
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (w_push) wr_d = wr_q + PW'(1);
      if (w_pop)  rd_d = rd_q + PW'(1);
      count_d = count_q + CW'(w_push) - CW'(w_pop);
      if (w_issue) begin
        inflight_d = 1'b1;
        ipc_d      = fpc_q;
        fpc_d      = fpc_q + XLEN'(4);
      end
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q      <= RESET_PC;
      inflight_q <= 1'b0;
      ipc_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
    end else begin
      fpc_q      <= fpc_d;
      inflight_q <= inflight_d;
      ipc_q      <= ipc_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      mem_inst_q[wr_q] <= i_RomData_32;
      mem_pc_q[wr_q]   <= ipc_q;
    end
  end

  // Head presentation and ROM port
  always_comb begin
    o_RomAddr_32 = fpc_q;
    o_RomReq_1   = w_issue;
    o_Valid_1    = (count_q != '0);
    o_Inst_32    = mem_inst_q[rd_q];
    o_PC_32      = mem_pc_q[rd_q];
    o_PCPlus4_32 = mem_pc_q[rd_q] + XLEN'(4);
    o_Count      = count_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_prefetch_queue
// Brief    : Self-checking bench for inst_prefetch_queue; queue-based model
//            compared every cycle, plus directed scenario literals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_prefetch_queue;

  localparam int TB_DEPTH = 4;
  localparam int CW = $clog2(TB_DEPTH+1);

  logic          clk;
  logic          rst;
  logic          i_Redirect_1;
  logic [31:0]   i_RedirectPC_32;
  logic [31:0]   o_RomAddr_32;
  logic          o_RomReq_1;
  logic [31:0]   i_RomData_32;
  logic          o_Valid_1;
  logic [31:0]   o_Inst_32;
  logic [31:0]   o_PC_32;
  logic [31:0]   o_PCPlus4_32;
  logic          i_Ready_1;
  logic [CW-1:0] o_Count;

  inst_prefetch_queue #(.XLEN(32), .DEPTH(TB_DEPTH), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_Redirect_1    (i_Redirect_1),
    .i_RedirectPC_32 (i_RedirectPC_32),
    .o_RomAddr_32    (o_RomAddr_32),
    .o_RomReq_1      (o_RomReq_1),
    .i_RomData_32    (i_RomData_32),
    .o_Valid_1       (o_Valid_1),
    .o_Inst_32       (o_Inst_32),
    .o_PC_32         (o_PC_32),
    .o_PCPlus4_32    (o_PCPlus4_32),
    .i_Ready_1       (i_Ready_1),
    .o_Count         (o_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM word i holds value i
  function automatic logic [31:0] rom(input logic [31:0] a);
    return a >> 2;
  endfunction

  // Synchronous ROM: one cycle read latency
  always @(posedge clk) i_RomData_32 <= rom(o_RomAddr_32);

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue contents and fetch bookkeeping
  logic [31:0] mq_inst [$];
  logic [31:0] mq_pc   [$];
  logic [31:0] m_fpc;
  bit          m_inf;
  logic [31:0] m_ipc;

  // Per-cycle snapshot of DUT outputs
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_inst, s_pc, s_pc4, s_count;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, compare at negedge, advance model, step to posedge+1
  task automatic cycle(input bit r, input bit rd, input logic [31:0] rpc, input bit rdy);
    int sz;
    bit pop;
    bit e_req;
    rst = r; i_Redirect_1 = rd; i_RedirectPC_32 = rpc; i_Ready_1 = rdy;
    @(negedge clk);
    s_req = o_RomReq_1; s_addr = o_RomAddr_32; s_valid = o_Valid_1;
    s_inst = o_Inst_32; s_pc = o_PC_32; s_pc4 = o_PCPlus4_32; s_count = 32'(o_Count);
    sz    = mq_pc.size();
    pop   = (sz != 0) && rdy;
    e_req = !r && !rd && ((sz + int'(m_inf) - int'(pop)) < TB_DEPTH);
    chk("req",   32'(s_req), 32'(e_req));
    chk("addr",  s_addr, m_fpc);
    chk("valid", 32'(s_valid), 32'(sz != 0));
    chk("count", s_count, 32'(sz));
    chk("count_bound", 32'(s_count <= TB_DEPTH), 32'd1);
    if (sz != 0) begin
      chk("inst", s_inst, mq_inst[0]);
      chk("pc",   s_pc, mq_pc[0]);
      chk("pc4",  s_pc4, mq_pc[0] + 32'd4);
    end
    if (r) begin
      mq_inst.delete(); mq_pc.delete(); m_fpc = 32'h0; m_inf = 0; m_ipc = '0;
    end else if (rd) begin
      mq_inst.delete(); mq_pc.delete(); m_fpc = rpc; m_inf = 0;
    end else begin
      if (pop) begin
        void'(mq_inst.pop_front()); void'(mq_pc.pop_front());
      end
      if (m_inf) begin
        mq_inst.push_back(rom(m_ipc)); mq_pc.push_back(m_ipc);
      end
      if (e_req) begin
        m_ipc = m_fpc; m_fpc = m_fpc + 32'd4; m_inf = 1;
      end else begin
        m_inf = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] wrap_exp [5];
  logic [31:0] got_pc   [5];
  logic [31:0] got_pc4  [5];
  int          npops;

  initial begin
    rst = 1'b1; i_Redirect_1 = 1'b0; i_RedirectPC_32 = '0; i_Ready_1 = 1'b1;
    m_fpc = 32'h0; m_inf = 0; m_ipc = '0;
    @(posedge clk); #1;

    // Cold start
    repeat (3) cycle(1, 0, 0, 1);
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_count", s_count, 32'd0);
    chk("rst_addr",  s_addr, 32'h0);
    chk("rst_req",   32'(s_req), 32'd0);
    cycle(0, 0, 0, 1);
    chk("cold_req",  32'(s_req), 32'd1);
    chk("cold_addr", s_addr, 32'h0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    chk("cold_valid", 32'(s_valid), 32'd1);
    chk("cold_pc",    s_pc, 32'h0);
    chk("cold_inst",  s_inst, 32'h0);
    chk("cold_pc4",   s_pc4, 32'h4);
    cycle(0, 0, 0, 1);
    chk("cold_pc_next", s_pc, 32'h4);

    // Back-pressure fill and drain
    cycle(1, 0, 0, 1);
    repeat (10) cycle(0, 0, 0, 0);
    chk("bp_count", s_count, 32'd4);
    chk("bp_req",   32'(s_req), 32'd0);
    chk("bp_addr",  s_addr, 32'd16);
    cycle(0, 0, 0, 1);
    chk("bp_head0",  s_pc, 32'h0);
    chk("bp_resume", 32'(s_req), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 0, 0, 1);
      chk("bp_valid", 32'(s_valid), 32'd1);
      chk("bp_order", s_pc, 32'(4 * i));
    end

    // Redirect mid-stream
    cycle(1, 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 1);
    cycle(0, 1, 32'h100, 1);
    chk("rd_head_before", s_pc, 32'h4);
    cycle(0, 0, 0, 1);
    chk("rd_gap1",  32'(s_valid), 32'd0);
    chk("rd_addr",  s_addr, 32'h100);
    cycle(0, 0, 0, 1);
    chk("rd_gap2",  32'(s_valid), 32'd0);
    cycle(0, 0, 0, 1);
    chk("rd_tgt",   s_pc, 32'h100);
    cycle(0, 0, 0, 1);
    chk("rd_tgt1",  s_pc, 32'h104);

    // Redirect with full queue and simultaneous pop
    cycle(1, 0, 0, 1);
    repeat (8) cycle(0, 0, 0, 0);
    cycle(0, 1, 32'h40, 1);
    chk("full_count_pre", s_count, 32'd4);
    cycle(0, 0, 0, 1);
    chk("full_flushed", s_count, 32'd0);
    cycle(0, 0, 0, 1);
    chk("full_gap", 32'(s_valid), 32'd0);
    cycle(0, 0, 0, 1);
    chk("full_tgt", s_pc, 32'h40);

    // Address wrap-around with random ready
    wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0; wrap_exp[3] = 32'h4; wrap_exp[4] = 32'h8;
    cycle(0, 1, 32'hFFFF_FFF8, 1);
    npops = 0;
    for (int k = 0; k < 60 && npops < 5; k++) begin
      cycle(0, 0, 0, 1'($urandom_range(0, 1)));
      if (s_valid && i_Ready_1) begin
        got_pc[npops] = s_pc; got_pc4[npops] = s_pc4; npops++;
      end
    end
    chk("wrap_pops", 32'(npops), 32'd5);
    for (int j = 0; j < npops; j++) chk("wrap_pc", got_pc[j], wrap_exp[j]);
    if (npops >= 2) chk("wrap_pc4", got_pc4[1], 32'h0);

    // Reset mid-operation with a request in flight
    cycle(1, 0, 0, 1);
    repeat (4) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("mid_pre_count", s_count, 32'd3);
    cycle(0, 0, 0, 0);
    chk("mid_valid", 32'(s_valid), 32'd0);
    chk("mid_count", s_count, 32'd0);
    chk("mid_addr",  s_addr, 32'h0);
    cycle(0, 0, 0, 0);
    chk("mid_no_stale", s_count, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit r, rd, rdy;
      logic [31:0] tgt;
      r   = ($urandom_range(0, 199) == 0);
      rd  = ($urandom_range(0, 24) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                         : ($urandom & 32'hFFFF_FFFC);
      cycle(r, rd, tgt, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
